// File: rtl/mb_pkg.sv
// Shared types and pin map for the MiniByte external memory bus initiator.
package mb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      TURN = 2'd3
   } mb_bus_state_t;

   localparam int MB_PIN_ALE  = 7;
   localparam int MB_PIN_WE_N = 6;
   localparam int MB_PIN_OE_N = 5;
   localparam int MB_PIN_BUSY = 4;

   localparam logic [7:0] MB_PIN_IDLE = 8'h60;

   function automatic int mb_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [7:0] mb_strobes(input logic ale, input logic we_n,
                                             input logic oe_n, input logic busy);
      logic [7:0] s;
      s              = 8'h00;
      s[MB_PIN_ALE]  = ale;
      s[MB_PIN_WE_N] = we_n;
      s[MB_PIN_OE_N] = oe_n;
      s[MB_PIN_BUSY] = busy;
      return s;
   endfunction

endpackage

// File: rtl/mb_bus_master.sv
// Sequences single-byte core requests onto the multiplexed address/data uio bus.
// Outputs decode only from the state register and latched transfer registers.
module mb_bus_master
   import mb_pkg::*;
#(
   parameter int ADDR_CYCLES = 1,
   parameter int TIMEOUT     = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_we,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic [7:0] pin_uo,
   output logic [7:0] pin_uio_out,
   output logic [7:0] pin_uio_oe,
   input  logic [7:0] pin_uio_in,
   input  logic       pin_wait
);

   // One counter serves both the address hold and the wait count.
   localparam int CNT_W = mb_max($clog2(TIMEOUT + 1), $clog2(ADDR_CYCLES + 1));
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   mb_bus_state_t    state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             we_r, we_s;
   logic [7:0]       addr_r, addr_s;
   logic [7:0]       wdata_r, wdata_s;
   logic [7:0]       rdata_r, rdata_s;
   logic             err_r, err_s;

   // Next-state, counter and transfer-register update.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      we_s    = we_r;
      addr_s  = addr_r;
      wdata_s = wdata_r;
      rdata_s = rdata_r;
      err_s   = err_r;
      case (state_r)
         IDLE: begin
            cnt_s = CNT_ZERO;
            if (req_valid) begin
               state_s = ADDR;
               we_s    = req_we;
               addr_s  = req_addr;
               wdata_s = req_wdata;
               rdata_s = 8'h00;
               err_s   = 1'b0;
            end else begin
               state_s = IDLE;
            end
         end
         ADDR: begin
            if (cnt_r == ADDR_LAST) begin
               state_s = DATA;
               cnt_s   = CNT_ZERO;
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         DATA: begin
            if (!pin_wait) begin
               state_s = TURN;
               if (!we_r) begin
                  rdata_s = pin_uio_in;
               end else begin
                  rdata_s = 8'h00;
               end
            end else if (cnt_r == TO_LAST) begin
               // Wait never released: abort with error and no data.
               state_s = TURN;
               cnt_s   = TO_MAX;
               err_s   = 1'b1;
               rdata_s = 8'h00;
            end else if (cnt_r == TO_MAX) begin
               cnt_s   = cnt_r;
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         TURN: begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
         end
         default: begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // State and transfer registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         we_r    <= 1'b0;
         addr_r  <= 8'h00;
         wdata_r <= 8'h00;
         rdata_r <= 8'h00;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         we_r    <= we_s;
         addr_r  <= addr_s;
         wdata_r <= wdata_s;
         rdata_r <= rdata_s;
         err_r   <= err_s;
      end
   end

   // Pin and response decode from registered state only.
   always_comb begin
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      rsp_rdata   = 8'h00;
      rsp_err     = 1'b0;
      pin_uo      = MB_PIN_IDLE;
      pin_uio_out = 8'h00;
      pin_uio_oe  = 8'h00;
      case (state_r)
         IDLE: begin
            req_ready = 1'b1;
         end
         ADDR: begin
            pin_uo      = mb_strobes(1'b1, 1'b1, 1'b1, 1'b1);
            pin_uio_out = addr_r;
            pin_uio_oe  = 8'hFF;
         end
         DATA: begin
            if (we_r) begin
               pin_uo      = mb_strobes(1'b0, 1'b0, 1'b1, 1'b1);
               pin_uio_out = wdata_r;
               pin_uio_oe  = 8'hFF;
            end else begin
               pin_uo      = mb_strobes(1'b0, 1'b1, 1'b0, 1'b1);
               pin_uio_out = 8'h00;
               pin_uio_oe  = 8'h00;
            end
         end
         TURN: begin
            pin_uo    = mb_strobes(1'b0, 1'b1, 1'b1, 1'b1);
            rsp_valid = 1'b1;
            rsp_rdata = rdata_r;
            rsp_err   = err_r;
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

endmodule
